// File: rtl/id_pkg.sv
// rtl/id_pkg.sv - MIPS R-type field positions, op/funct constants and ALU op codes
package id_pkg;

  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 26;
  localparam int RS_MSB    = 25;
  localparam int RS_LSB    = 21;
  localparam int RT_MSB    = 20;
  localparam int RT_LSB    = 16;
  localparam int RD_MSB    = 15;
  localparam int RD_LSB    = 11;
  localparam int SHAMT_MSB = 10;
  localparam int SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5;
  localparam int FUNCT_LSB = 0;

  localparam logic [5:0] OP_RTYPE = 6'b000000;

  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;

  // sub and subu share one ALU code: the ALU does not trap on overflow.
  typedef enum logic [3:0] {
    ALU_ADDU = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_AND  = 4'b0011,
    ALU_OR   = 4'b0100,
    ALU_SLT  = 4'b0101
  } aluop_e;

  typedef struct packed {
    logic   legal;
    aluop_e aluop;
  } decode_t;

  function automatic decode_t decode(input logic [5:0] op, input logic [5:0] funct);
    decode_t d;
    d.legal = (op == OP_RTYPE);
    d.aluop = ALU_ADDU;
    case (funct)
      FN_ADDU: d.aluop = ALU_ADDU;
      FN_SUBU: d.aluop = ALU_SUB;
      FN_SUB:  d.aluop = ALU_SUB;
      FN_ADD:  d.aluop = ALU_ADD;
      FN_AND:  d.aluop = ALU_AND;
      FN_OR:   d.aluop = ALU_OR;
      FN_SLT:  d.aluop = ALU_SLT;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/regfile.sv
// rtl/regfile.sv - 32x32 register file, two async read ports, one sync write port, $0 hardwired
module regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr_a,
  input  logic [4:0]  raddr_b,
  output logic [31:0] rdata_a,
  output logic [31:0] rdata_b
);

  logic [31:0] mem [32];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_a = (raddr_a == 5'd0) ? '0 : mem[raddr_a];
  assign rdata_b = (raddr_b == 5'd0) ? '0 : mem[raddr_b];

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - MIPS decode stage: decode, write-back bypass, pending scoreboard, EX pipeline register
module id_stage
  import id_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] inst,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [31:0] ex_a,
  output logic [31:0] ex_b,
  output logic [3:0]  ex_aluop,
  output logic [4:0]  ex_rd,
  input  logic        wb_en,
  input  logic [4:0]  wb_addr,
  input  logic [31:0] wb_data,
  output logic        illegal
);

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd;
  logic [4:0]  unused_shamt;
  decode_t     dec;
  logic [31:0] rf_a, rf_b, opnd_a, opnd_b;
  logic [31:0] pending, set_mask, clr_mask;
  logic        rs_wb, rt_wb, hazard, accept, take_legal;

  assign op           = inst[OP_MSB:OP_LSB];
  assign rs           = inst[RS_MSB:RS_LSB];
  assign rt           = inst[RT_MSB:RT_LSB];
  assign rd           = inst[RD_MSB:RD_LSB];
  assign unused_shamt = inst[SHAMT_MSB:SHAMT_LSB];
  assign funct        = inst[FUNCT_MSB:FUNCT_LSB];
  assign dec          = decode(op, funct);

  regfile u_regfile (
    .clk     (clk),
    .rst     (rst),
    .we      (wb_en),
    .waddr   (wb_addr),
    .wdata   (wb_data),
    .raddr_a (rs),
    .raddr_b (rt),
    .rdata_a (rf_a),
    .rdata_b (rf_b)
  );

  // A write-back landing this cycle both forwards its data and retires its pending bit.
  assign rs_wb  = wb_en && (wb_addr != 5'd0) && (wb_addr == rs);
  assign rt_wb  = wb_en && (wb_addr != 5'd0) && (wb_addr == rt);
  assign opnd_a = rs_wb ? wb_data : rf_a;
  assign opnd_b = rt_wb ? wb_data : rf_b;

  assign hazard = dec.legal &&
                  (((rs != 5'd0) && pending[rs] && !rs_wb) ||
                   ((rt != 5'd0) && pending[rt] && !rt_wb));

  assign inst_ready = !rst && (!ex_valid || ex_ready) && !hazard;
  assign accept     = inst_valid && inst_ready;
  assign take_legal = accept && dec.legal;

  assign set_mask = (take_legal && rd != 5'd0) ? (32'd1 << rd) : '0;
  assign clr_mask = wb_en ? (32'd1 << wb_addr) : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      pending  <= '0;
      ex_valid <= 1'b0;
      ex_a     <= '0;
      ex_b     <= '0;
      ex_aluop <= '0;
      ex_rd    <= '0;
      illegal  <= 1'b0;
    end else begin
      // Set wins over clear: the new producer is still outstanding.
      pending <= (pending & ~clr_mask) | set_mask;
      illegal <= accept && !dec.legal;
      if (take_legal) begin
        ex_valid <= 1'b1;
        ex_a     <= opnd_a;
        ex_b     <= opnd_b;
        ex_aluop <= dec.aluop;
        ex_rd    <= rd;
      end else if (ex_ready) begin
        ex_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage with directed scenarios and a randomized reference model
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst, inst_valid, inst_ready, ex_valid, ex_ready, wb_en, illegal;
  logic [31:0] inst, ex_a, ex_b, wb_data;
  logic [3:0]  ex_aluop;
  logic [4:0]  ex_rd, wb_addr;

  always #5 clk = ~clk;

  id_stage dut (
    .clk        (clk),
    .rst        (rst),
    .inst_valid (inst_valid),
    .inst_ready (inst_ready),
    .inst       (inst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_a       (ex_a),
    .ex_b       (ex_b),
    .ex_aluop   (ex_aluop),
    .ex_rd      (ex_rd),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .illegal    (illegal)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  logic [31:0] m_reg [32];
  bit          m_pend [32];
  logic        m_exv, m_ill;
  logic [31:0] m_a, m_b;
  logic [3:0]  m_op;
  logic [4:0]  m_rd;
  logic        exp_ready, seen_ready;

  logic [5:0] fn_tab [7] = '{6'h21, 6'h23, 6'h22, 6'h20, 6'h24, 6'h25, 6'h2a};
  int         code_tab [7] = '{0, 1, 1, 2, 3, 4, 5};

  function automatic logic [31:0] rtype(input int rs_n, input int rt_n, input int rd_n, input logic [5:0] fn);
    return {6'b0, rs_n[4:0], rt_n[4:0], rd_n[4:0], 5'b0, fn};
  endfunction

  // -1 for anything the stage must reject
  function automatic int ref_code(input logic [31:0] w);
    if (w[31:26] != 6'd0) return -1;
    for (int i = 0; i < 7; i++) if (w[5:0] == fn_tab[i]) return code_tab[i];
    return -1;
  endfunction

  task automatic apply(input logic r, input logic iv, input logic [31:0] w, input logic er,
                       input logic we, input int wa, input logic [31:0] wd);
    int  code, s, t, d;
    bit  hz, acc;
    logic [31:0] va, vb;
    rst = r; inst_valid = iv; inst = w; ex_ready = er;
    wb_en = we; wb_addr = wa[4:0]; wb_data = wd;
    #2;
    seen_ready = inst_ready;
    code = ref_code(w);
    s = int'(w[25:21]); t = int'(w[20:16]); d = int'(w[15:11]);
    hz = (code >= 0) &&
         ((s != 0 && m_pend[s] && !(we && wa == s)) || (t != 0 && m_pend[t] && !(we && wa == t)));
    exp_ready = !r && (!m_exv || er) && !hz;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
      m_exv = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0; m_ill = 0;
    end else begin
      acc = iv && exp_ready;
      va = (s == 0) ? 32'd0 : ((we && wa == s) ? wd : m_reg[s]);
      vb = (t == 0) ? 32'd0 : ((we && wa == t) ? wd : m_reg[t]);
      m_ill = acc && code < 0;
      if (acc && code >= 0) begin
        m_exv = 1; m_a = va; m_b = vb; m_op = code[3:0]; m_rd = d[4:0];
      end else if (er) begin
        m_exv = 0;
      end
      if (we && wa != 0) m_reg[wa] = wd;
      if (we) m_pend[wa] = 0;
      if (acc && code >= 0 && d != 0) m_pend[d] = 1;
    end
    #1;
  endtask

  task automatic test_reset;
    apply(1, 1, rtype(1, 2, 3, 6'h21), 1, 1, 4, 32'hdead);
    n_cmp++; if (seen_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready got %0b want 0", seen_ready); end
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL reset_ex_valid got %0b want 0", ex_valid); end
    n_cmp++; if ({ex_a, ex_b, ex_aluop, ex_rd, illegal} !== 74'd0)
      begin n_bad++; $display("FAIL reset_ex_fields got a=%h b=%h op=%h rd=%0d ill=%0b want all 0", ex_a, ex_b, ex_aluop, ex_rd, illegal); end
    apply(0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (seen_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after got %0b want 1", seen_ready); end
  endtask

  task automatic test_basic;
    apply(0, 0, 0, 1, 1, 1, 5);
    apply(0, 0, 0, 1, 1, 2, 7);
    apply(0, 1, rtype(1, 2, 3, 6'h21), 1, 0, 0, 0);
    n_cmp++; if (seen_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready got %0b want 1", seen_ready); end
    n_cmp++; if ({ex_valid, ex_a, ex_b, ex_aluop, ex_rd} !== {1'b1, 32'd5, 32'd7, 4'd0, 5'd3})
      begin n_bad++; $display("FAIL basic_ex got v=%0b a=%0d b=%0d op=%0d rd=%0d want 1 5 7 0 3", ex_valid, ex_a, ex_b, ex_aluop, ex_rd); end
  endtask

  task automatic test_hazard_bypass;
    apply(0, 1, rtype(3, 1, 4, 6'h23), 1, 0, 0, 0);
    n_cmp++; if (seen_ready !== 1'b0) begin n_bad++; $display("FAIL hazard_ready got %0b want 0", seen_ready); end
    n_cmp++; if (ex_valid !== 1'b0) begin n_bad++; $display("FAIL hazard_drain got %0b want 0", ex_valid); end
    apply(0, 1, rtype(3, 1, 4, 6'h23), 1, 1, 3, 12);
    n_cmp++; if (seen_ready !== 1'b1) begin n_bad++; $display("FAIL bypass_ready got %0b want 1", seen_ready); end
    n_cmp++; if ({ex_valid, ex_a, ex_b, ex_aluop, ex_rd} !== {1'b1, 32'd12, 32'd5, 4'd1, 5'd4})
      begin n_bad++; $display("FAIL bypass_ex got v=%0b a=%0d b=%0d op=%0d rd=%0d want 1 12 5 1 4", ex_valid, ex_a, ex_b, ex_aluop, ex_rd); end
  endtask

  task automatic test_stall;
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, rtype(1, 2, 6, 6'h25), 0, k == 1, 1, 100);
      n_cmp++; if (seen_ready !== 1'b0) begin n_bad++; $display("FAIL stall_ready[%0d] got %0b want 0", k, seen_ready); end
      n_cmp++; if ({ex_valid, ex_a, ex_b, ex_aluop, ex_rd} !== {1'b1, 32'd12, 32'd5, 4'd1, 5'd4})
        begin n_bad++; $display("FAIL stall_hold[%0d] got v=%0b a=%0d b=%0d op=%0d rd=%0d want 1 12 5 1 4", k, ex_valid, ex_a, ex_b, ex_aluop, ex_rd); end
    end
    apply(0, 1, rtype(1, 2, 6, 6'h25), 1, 0, 0, 0);
    n_cmp++; if (seen_ready !== 1'b1) begin n_bad++; $display("FAIL release_ready got %0b want 1", seen_ready); end
    n_cmp++; if ({ex_valid, ex_a, ex_b, ex_aluop, ex_rd} !== {1'b1, 32'd100, 32'd7, 4'd4, 5'd6})
      begin n_bad++; $display("FAIL release_ex got v=%0b a=%0d b=%0d op=%0d rd=%0d want 1 100 7 4 6", ex_valid, ex_a, ex_b, ex_aluop, ex_rd); end
  endtask

  task automatic test_illegal;
    apply(0, 0, 0, 1, 0, 0, 0);
    apply(0, 1, 32'h0000_0000, 1, 0, 0, 0);
    n_cmp++; if (seen_ready !== 1'b1) begin n_bad++; $display("FAIL sll_ready got %0b want 1", seen_ready); end
    n_cmp++; if ({illegal, ex_valid} !== 2'b10) begin n_bad++; $display("FAIL sll_pulse got ill=%0b v=%0b want 1 0", illegal, ex_valid); end
    // Illegal word naming a pending $4 in rs: no hazard, and rd=9 must not become pending
    apply(0, 1, {6'h08, 5'd4, 5'd0, 5'd9, 5'd0, 6'h21}, 1, 0, 0, 0);
    n_cmp++; if (seen_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_nohazard got %0b want 1", seen_ready); end
    apply(0, 0, 0, 1, 0, 0, 0);
    n_cmp++; if (illegal !== 1'b0) begin n_bad++; $display("FAIL illegal_one_cycle got %0b want 0", illegal); end
    apply(0, 1, rtype(9, 0, 10, 6'h20), 1, 0, 0, 0);
    n_cmp++; if (seen_ready !== 1'b1) begin n_bad++; $display("FAIL illegal_no_pend got %0b want 1", seen_ready); end
    n_cmp++; if ({ex_valid, ex_aluop, ex_rd} !== {1'b1, 4'd2, 5'd10})
      begin n_bad++; $display("FAIL add_after_illegal got v=%0b op=%0d rd=%0d want 1 2 10", ex_valid, ex_aluop, ex_rd); end
  endtask

  task automatic test_zero_reg;
    apply(0, 0, 0, 1, 1, 0, 99);
    apply(0, 1, rtype(0, 0, 5, 6'h2a), 1, 0, 0, 0);
    n_cmp++; if ({ex_valid, ex_a, ex_b, ex_aluop, ex_rd} !== {1'b1, 32'd0, 32'd0, 4'd5, 5'd5})
      begin n_bad++; $display("FAIL slt_zero got v=%0b a=%0d b=%0d op=%0d rd=%0d want 1 0 0 5 5", ex_valid, ex_a, ex_b, ex_aluop, ex_rd); end
    apply(0, 1, rtype(1, 2, 0, 6'h20), 1, 0, 0, 0);
    apply(0, 1, rtype(0, 0, 12, 6'h24), 1, 0, 0, 0);
    n_cmp++; if (seen_ready !== 1'b1) begin n_bad++; $display("FAIL zero_never_pending got %0b want 1", seen_ready); end
  endtask

  task automatic test_reset_midop;
    apply(0, 1, rtype(1, 2, 7, 6'h20), 1, 0, 0, 0);
    apply(0, 0, 0, 0, 0, 0, 0);
    n_cmp++; if (ex_valid !== 1'b1) begin n_bad++; $display("FAIL midop_setup got %0b want 1", ex_valid); end
    apply(1, 1, rtype(1, 2, 8, 6'h20), 1, 1, 3, 55);
    n_cmp++; if (seen_ready !== 1'b0) begin n_bad++; $display("FAIL midop_rst_ready got %0b want 0", seen_ready); end
    n_cmp++; if ({ex_valid, ex_a, ex_b, ex_aluop, ex_rd, illegal} !== 75'd0)
      begin n_bad++; $display("FAIL midop_flush got v=%0b a=%h b=%h op=%0d rd=%0d ill=%0b want all 0", ex_valid, ex_a, ex_b, ex_aluop, ex_rd, illegal); end
    for (int r = 1; r < 32; r++) begin
      apply(0, 1, rtype(r, r, 0, 6'h25), 1, 0, 0, 0);
      n_cmp++; if ({seen_ready, ex_valid, ex_a, ex_b} !== {2'b11, 64'd0})
        begin n_bad++; $display("FAIL midop_reg[%0d] got rdy=%0b v=%0b a=%h b=%h want 1 1 0 0", r, seen_ready, ex_valid, ex_a, ex_b); end
    end
  endtask

  task automatic test_random;
    logic [31:0] w;
    logic [5:0]  op, fn;
    for (int n = 0; n < 1500; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 6'($urandom_range(1, 63)) : 6'd0;
      fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fn_tab[$urandom_range(0, 6)];
      w  = {op, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom), fn};
      apply($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0, w, $urandom_range(0, 3) != 0,
            $urandom_range(0, 1) == 1, $urandom_range(0, 7), $urandom);
      n_cmp++; if (seen_ready !== exp_ready) begin n_bad++; $display("FAIL rnd_ready[%0d] got %0b want %0b", n, seen_ready, exp_ready); end
      n_cmp++; if ({ex_valid, illegal} !== {m_exv, m_ill})
        begin n_bad++; $display("FAIL rnd_valid[%0d] got v=%0b ill=%0b want %0b %0b", n, ex_valid, illegal, m_exv, m_ill); end
      n_cmp++; if ({ex_a, ex_b, ex_aluop, ex_rd} !== {m_a, m_b, m_op, m_rd})
        begin n_bad++; $display("FAIL rnd_ex[%0d] got a=%h b=%h op=%0d rd=%0d want %h %h %0d %0d", n, ex_a, ex_b, ex_aluop, ex_rd, m_a, m_b, m_op, m_rd); end
    end
  endtask

  initial begin
    rst = 1; inst_valid = 0; inst = 0; ex_ready = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    for (int i = 0; i < 32; i++) begin m_reg[i] = 0; m_pend[i] = 0; end
    m_exv = 0; m_ill = 0; m_a = 0; m_b = 0; m_op = 0; m_rd = 0;
    @(posedge clk); #1;
    test_reset;
    test_basic;
    test_hazard_bypass;
    test_stall;
    test_illegal;
    test_zero_reg;
    test_reset_midop;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/id_stage.md
ID_STAGE -- requirements
Module: id_stage

Interface
REQ-001 SHALL have: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset, synchronous, active-high.
REQ-003 SHALL have: inst_valid  input  1  upstream instruction valid.
REQ-004 SHALL have: inst_ready  output  1  stage accepts inst this cycle.
REQ-005 SHALL have: inst  input  32  MIPS instruction word (op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0]).
REQ-006 SHALL have: ex_valid  output  1  operands/aluop valid for the ALU stage.
REQ-007 SHALL have: ex_ready  input  1  ALU stage consumes this cycle.
REQ-008 SHALL have: ex_a, ex_b  output  32 each  rs/rt operand values.
REQ-009 SHALL have: ex_aluop  output  4  ALU operation code; ex_rd  output  5  destination register.
REQ-010 SHALL have: wb_en  input  1; wb_addr  input  5; wb_data  input  32  register write-back port.
REQ-011 SHALL have: illegal  output  1  one-cycle pulse on an accepted unsupported instruction.

Function
REQ-012 SHALL contain a 32x32 register file; reads of $0 return 0; writes to $0 ignored.
REQ-013 SHALL apply a write-back at the clock edge when wb_en=1 and wb_addr!=0.
REQ-014 SHALL bypass: same-cycle read of rs/rt equal to wb_addr (nonzero, wb_en=1) returns wb_data.
REQ-015 SHALL decode only op=000000, with funct: 100001 addu->0000, 100011 subu->0001, 100010 sub->0001, 100000 add->0010, 100100 and->0011, 100101 or->0100, 101010 slt->0101.
REQ-016 SHALL treat any other op/funct as illegal: consumed, illegal=1 for the following cycle, no ex_valid, no scoreboard change.
REQ-017 SHALL keep a 32-bit pending scoreboard; bit rd set when a legal inst with rd!=0 is accepted; bit cleared when wb_en=1 to that address.
REQ-018 SHALL, on simultaneous set and clear of the same bit, leave it set.
REQ-019 SHALL drive inst_ready = (!ex_valid || ex_ready) && !hazard; hazard = rs or rt (nonzero) pending and not being cleared by wb this cycle.
REQ-020 SHALL evaluate hazard only for a legal inst; illegal insts accept on (!ex_valid || ex_ready).
REQ-021 SHALL register ex_a/ex_b/ex_aluop/ex_rd on accept; latency inst accept -> ex_valid = 1 cycle.
REQ-022 SHALL hold all ex_* stable while ex_valid=1 and ex_ready=0; held operands are not refreshed by later write-backs.
REQ-023 SHALL clear ex_valid after ex_ready=1 when no new legal inst is accepted that cycle; back-to-back accept keeps ex_valid=1 (full throughput).
REQ-024 SHALL not change ex_* contents when ex_valid=0 and nothing is accepted.

Reset
REQ-025 SHALL on rst=1 clear all 32 registers, the scoreboard, ex_valid, ex_a, ex_b, ex_aluop, ex_rd and illegal to 0.
REQ-026 SHALL drive inst_ready=0 while rst=1; rst overrides any same-cycle accept or write-back.
REQ-027 SHALL discard an in-flight ex_* instruction on mid-operation reset; no partial state remains.

Structure
REQ-028 SHALL place aluop codes, op/funct constants and field bit positions in shared package id_pkg, also used by the ALU stage.
REQ-029 SHALL implement the storage as sub-module regfile (2 async read ports, 1 sync write port, bypass excluded); decode, scoreboard and pipeline register live in id_stage.

Verification
REQ-030 SHALL cover: wb $1=5, $2=7; inst addu $3,$1,$2 with ex_ready=1 -> next cycle ex_valid=1, ex_a=5, ex_b=7, ex_aluop=0000, ex_rd=3.
REQ-031 SHALL cover: issue subu $4,$3,$1 while $3 pending -> inst_ready=0; wb $3=12 same cycle -> accepted, ex_a=12, ex_aluop=0001.
REQ-032 SHALL cover: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* unchanged, inst_ready=0; ex_ready=1 -> next inst accepted same cycle.
REQ-033 SHALL cover: inst 0x00000000 funct 000000 (sll) -> illegal=1 one cycle, ex_valid stays 0, scoreboard unchanged.
REQ-034 SHALL cover: slt $5,$0,$0 with wb $0=99 prior -> ex_a=0, ex_b=0, ex_aluop=0101; $0 never pending.
REQ-035 SHALL cover: rst asserted with ex_valid=1 and $7 pending -> next cycle ex_valid=0, all regs read 0, inst_ready=1 after rst drops.
